// File: rtl/in12_pkg.sv
// Shared types and constants for the IN-12 nixie scan driver.
package in12_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      DEAD,
      CATH_SETUP,
      CATH_STB,
      ANODE_SETUP,
      ANODE_STB
   } in12_state_t;

   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   // Non-decimal nibbles would light a random cathode; show nothing instead.
   function automatic logic [3:0] bcd_to_code(input logic [3:0] d);
      return (d > BCD_MAX) ? BLANK_CODE : d;
   endfunction

endpackage

// File: rtl/in12_strobe_timer.sv
// Loadable down-counter shared by every timed state of the scan sequence.
module in12_strobe_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   // A state loaded with N-1 therefore lasts exactly N cycles.
   assign done = (cnt_reg == '0);

endmodule

// File: rtl/in12_scan_driver.sv
// Multiplexed IN-12 driver: blank, dead time, cathode write, anode write, one tube per tick.
// Optional dimming (dim_level port and frame counter) is built when IN12_DIM_EN is defined.
module in12_scan_driver
   import in12_pkg::*;
#(
   parameter int DIGITS     = 10,
   parameter int STROBE_LEN = 4,
   parameter int DEAD_TIME  = 20
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                Enable,
   input  logic [DIGITS*4-1:0] digits,
`ifdef IN12_DIM_EN
   input  logic [2:0]          dim_level,
`endif
   output logic [7:0]          bus_data,
   output logic                in12_clear,
   output logic                in12_write_cathode,
   output logic                in12_write_anode,
   output logic                busy,
   output logic                overrun
);

   localparam int MAX_LEN = (STROBE_LEN > DEAD_TIME) ? STROBE_LEN : DEAD_TIME;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(STROBE_LEN - 1);
   localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_TIME - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

   in12_state_t         state_reg;
   logic [IDX_W-1:0]    anode_idx_reg;
   logic [DIGITS*4-1:0] snap_reg;
   logic [7:0]          bus_reg;
   logic                clear_reg;
   logic                cath_reg;
   logic                anode_reg;
   logic                busy_reg;
   logic                overrun_reg;
`ifdef IN12_DIM_EN
   logic [2:0]          frame_cnt_reg;
   logic                skip_reg;
`endif

   logic                tmr_load;
   logic [CNT_W-1:0]    tmr_val;
   logic                tmr_done;
   logic [3:0]          snap_digit [DIGITS];
   logic [IDX_W-1:0]    idx_next;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign snap_digit[gi] = snap_reg[4*gi +: 4];
      end
   endgenerate

   assign idx_next = (anode_idx_reg == IDX_LAST) ? '0 : anode_idx_reg + IDX_W'(1);

   // The timer is reloaded on the edge that enters each timed state.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = STB_LOAD;
      case (state_reg)
         IDLE:        tmr_load = Enable;
         CLEAR: begin
            tmr_load = tmr_done;
            tmr_val  = DEAD_LOAD;
         end
         CATH_SETUP,
         ANODE_SETUP: tmr_load = 1'b1;
         default:     tmr_load = 1'b0;
      endcase
   end

   in12_strobe_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .load    (tmr_load),
      .load_val(tmr_val),
      .done    (tmr_done)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg     <= IDLE;
         anode_idx_reg <= '0;
         snap_reg      <= '0;
         bus_reg       <= '0;
         clear_reg     <= 1'b0;
         cath_reg      <= 1'b0;
         anode_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         overrun_reg   <= 1'b0;
`ifdef IN12_DIM_EN
         frame_cnt_reg <= '0;
         skip_reg      <= 1'b0;
`endif
      end else begin
         if (Enable && state_reg != IDLE) overrun_reg <= 1'b1;
         case (state_reg)
            IDLE: begin
               bus_reg <= '0;
               if (Enable) begin
                  state_reg <= CLEAR;
                  clear_reg <= 1'b1;
                  busy_reg  <= 1'b1;
                  if (anode_idx_reg == '0) snap_reg <= digits;
`ifdef IN12_DIM_EN
                  skip_reg  <= (frame_cnt_reg < dim_level);
`endif
               end
            end
            CLEAR: begin
               if (tmr_done) begin
                  state_reg <= DEAD;
                  clear_reg <= 1'b0;
               end
            end
            DEAD: begin
               if (tmr_done) begin
`ifdef IN12_DIM_EN
                  if (skip_reg) begin
                     state_reg     <= IDLE;
                     busy_reg      <= 1'b0;
                     anode_idx_reg <= idx_next;
                     if (anode_idx_reg == IDX_LAST) frame_cnt_reg <= frame_cnt_reg + 3'd1;
                  end else begin
                     state_reg <= CATH_SETUP;
                     bus_reg   <= {4'h0, bcd_to_code(snap_digit[anode_idx_reg])};
                  end
`else
                  state_reg <= CATH_SETUP;
                  bus_reg   <= {4'h0, bcd_to_code(snap_digit[anode_idx_reg])};
`endif
               end
            end
            CATH_SETUP: begin
               state_reg <= CATH_STB;
               cath_reg  <= 1'b1;
            end
            CATH_STB: begin
               if (tmr_done) begin
                  state_reg <= ANODE_SETUP;
                  cath_reg  <= 1'b0;
                  bus_reg   <= 8'(anode_idx_reg);
               end
            end
            ANODE_SETUP: begin
               state_reg <= ANODE_STB;
               anode_reg <= 1'b1;
            end
            ANODE_STB: begin
               if (tmr_done) begin
                  state_reg     <= IDLE;
                  anode_reg     <= 1'b0;
                  busy_reg      <= 1'b0;
                  bus_reg       <= '0;
                  anode_idx_reg <= idx_next;
`ifdef IN12_DIM_EN
                  if (anode_idx_reg == IDX_LAST) frame_cnt_reg <= frame_cnt_reg + 3'd1;
`endif
               end
            end
            default: begin
               state_reg <= IDLE;
               clear_reg <= 1'b0;
               cath_reg  <= 1'b0;
               anode_reg <= 1'b0;
               busy_reg  <= 1'b0;
               bus_reg   <= '0;
            end
         endcase
      end
   end

   assign bus_data           = bus_reg;
   assign in12_clear         = clear_reg;
   assign in12_write_cathode = cath_reg;
   assign in12_write_anode   = anode_reg;
   assign busy               = busy_reg;
   assign overrun            = overrun_reg;

endmodule

// File: doc/in12_scan_driver.md
Name: in12_scan_driver

Overview:
- Multiplexed IN-12 nixie display driver on the emulator's shared 8-bit output bus.
- Consumes BCD digits from the DekatronPC counters and the 1 ms tick.
- Per tick: blanks the tubes, waits a dead time, writes the cathode code, then writes the anode index, advancing one tube per tick.
- Produces the in12_clear / in12_write_cathode / in12_write_anode strobes and the bus byte that the top-level bus mux forwards to emulData.

Parameters:
- DIGITS, 10, number of multiplexed tubes; anode index range 0..DIGITS-1 (max 16).
- STROBE_LEN, 4, width in Clk cycles of each clear/cathode/anode strobe (>=1).
- DEAD_TIME, 20, blanking cycles between clear and cathode write, for anti-ghosting (>=1).

Ports:
- Clk  input  1  system clock (Clock_1us domain).
- Rst_n  input  1  asynchronous active-low reset.
- Enable  input  1  1 ms tick, one Clk wide; starts one digit cycle.
- digits  input  DIGITS*4  packed BCD; digit i = digits[4*i+3:4*i].
- bus_data  output  8  byte for the emulator output bus.
- in12_clear  output  1  clear strobe.
- in12_write_cathode  output  1  cathode latch strobe.
- in12_write_anode  output  1  anode latch strobe.
- busy  output  1  high whenever state != IDLE.
- overrun  output  1  sticky; set when Enable arrives while busy.

Behaviour:
- Interface: one clock, Clk. Rst_n is asynchronous and active-low.
- Reset: state = IDLE. All strobes, busy, overrun and bus_data = 0. anode_idx = 0. Snapshot register = 0. Reset mid-sequence drops strobes immediately; no resume.
- All outputs are registered and glitch-free.
- Strobes are mutually exclusive.
- States:
  - IDLE: bus_data = 0. Enable = 1 moves to CLEAR on the next edge.
  - CLEAR: in12_clear = 1 for STROBE_LEN cycles. On entry with anode_idx == 0, the digits vector is snapshotted so each frame is coherent.
  - DEAD: DEAD_TIME cycles with everything low.
  - CATH_SETUP: 1 cycle. bus_data = {4'h0, code}. code = snapshot digit[anode_idx], or BLANK_CODE 4'hF if the value is >9.
  - CATH_STB: bus_data held; in12_write_cathode = 1 for STROBE_LEN cycles.
  - ANODE_SETUP: 1 cycle. bus_data = {4'h0, anode_idx}.
  - ANODE_STB: bus_data held; in12_write_anode = 1 for STROBE_LEN cycles. Then go to IDLE, and anode_idx increments, wrapping DIGITS-1 -> 0.
- Latency: Enable sampled at edge t gives in12_clear high from t+1. busy lasts exactly 3*STROBE_LEN + DEAD_TIME + 2 cycles (34 at defaults).
- Enable while busy: ignored for sequencing and sets overrun. Enable in the same cycle the sequence returns to IDLE is also ignored.
- Changes on digits outside CLEAR with anode_idx == 0 have no effect on the current frame.
- Duration counter: loaded on each state entry, decremented to 0, width $clog2 of max(STROBE_LEN, DEAD_TIME) + 1.

Optional Feature:
- Macro: IN12_DIM_EN.
- With the macro:
  - Adds input port dim_level [2:0].
  - Adds a 3-bit frame counter that increments each time anode_idx wraps to 0.
  - If frame_cnt < dim_level at CLEAR entry, the sequence runs CLEAR and DEAD, then returns to IDLE with no cathode/anode writes. anode_idx still advances.
  - dim_level = 0 means full brightness; 7 means 1/8 duty.
- Without the macro: port and counter are absent, and every tick writes the tube.

Decomposition:
- Package in12_pkg: state enum (IDLE, CLEAR, DEAD, CATH_SETUP, CATH_STB, ANODE_SETUP, ANODE_STB), BLANK_CODE = 4'hF, BCD_MAX = 9.
- Sub-module in12_strobe_timer: loadable down-counter with a done flag, shared by all timed states.

Test Plan:
- Reset, then one Enable with digits[3:0] = 5:
  - clear high cycles 1-4;
  - cathode strobe cycles 26-29 with bus = 0x05;
  - anode strobe cycles 31-34 with bus = 0x00;
  - busy is 34 cycles.
- Ten Enables at 1 ms: anode bus values 0..9, then 0 again; cathode codes follow the snapshot even when digits change mid-frame.
- Digit value 0xC: cathode bus = 0x0F (blank).
- Enable pulse during DEAD: no extra sequence, overrun = 1 until Rst_n.
- Rst_n low during CATH_STB: in12_write_cathode = 0 immediately. After release, the next Enable restarts at anode 0.
- IN12_DIM_EN with dim_level = 4: only frames with frame_cnt 4..7 produce cathode/anode strobes; clear still occurs on every tick.
